// File: rtl/ff_fifo_any_depth_with_levels_if.sv
// Handshake and status bundle for the any-depth show-ahead FIFO.
// The FIFO takes the slave side; the producer/consumer takes the master side.
interface ff_fifo_any_depth_with_levels_if #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 5
);
  localparam int unsigned count_w = $clog2(depth + 1);

  logic               push;
  logic               pop;
  logic [width-1:0]   write_data;
  logic [width-1:0]   read_data;
  logic               empty;
  logic               full;
  logic [count_w-1:0] count;
  logic               almost_empty;
  logic               almost_full;
  logic               overflow;
  logic               underflow;

  modport master (
    output push, pop, write_data,
    input  read_data, empty, full, count, almost_empty, almost_full,
           overflow, underflow
  );

  modport slave (
    input  push, pop, write_data,
    output read_data, empty, full, count, almost_empty, almost_full,
           overflow, underflow
  );
endinterface

// File: rtl/ff_fifo_any_depth_with_levels.sv
// Flip-flop show-ahead FIFO of any depth >= 2 with occupancy count,
// programmable almost flags and sticky overflow/underflow error flags.
module ff_fifo_any_depth_with_levels #(
  parameter int unsigned width                         = 8,
  parameter int unsigned depth                         = 5,
  parameter int unsigned almost_full_level             = depth - 1,
  parameter int unsigned almost_empty_level            = 1,
  parameter bit          allow_push_when_full_with_pop = 1'b1
) (
  input logic clk,
  input logic rst,
  ff_fifo_any_depth_with_levels_if.slave bus
);
  localparam int unsigned ptr_w   = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned count_w = $clog2(depth + 1);

  logic [width-1:0]   mem [depth];
  logic [ptr_w-1:0]   wr_ptr;
  logic [ptr_w-1:0]   rd_ptr;
  logic [count_w-1:0] count_q;
  logic               overflow_q;
  logic               underflow_q;

  logic empty_c;
  logic full_c;
  logic push_ok;
  logic pop_ok;

  // Flags come from the count register only, so they settle right after the edge.
  always_comb begin
    empty_c = (count_q == '0);
    full_c  = (count_q == count_w'(depth));
    pop_ok  = bus.pop & ~empty_c;
    push_ok = bus.push & (~full_c | (bus.pop & allow_push_when_full_with_pop));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == ptr_w'(depth - 1)) ? '0 : wr_ptr + ptr_w'(1);
      if (pop_ok)
        rd_ptr <= (rd_ptr == ptr_w'(depth - 1)) ? '0 : rd_ptr + ptr_w'(1);
      if (push_ok && !pop_ok)
        count_q <= count_q + count_w'(1);
      else if (pop_ok && !push_ok)
        count_q <= count_q - count_w'(1);
      if (bus.push && !push_ok)
        overflow_q <= 1'b1;
      if (bus.pop && empty_c)
        underflow_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset; unwritten entries are never observed.
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wr_ptr] <= bus.write_data;
  end

  always_comb begin
    bus.read_data    = mem[rd_ptr];
    bus.empty        = empty_c;
    bus.full         = full_c;
    bus.count        = count_q;
    bus.almost_empty = (count_q <= count_w'(almost_empty_level));
    bus.almost_full  = (count_q >= count_w'(almost_full_level));
    bus.overflow     = overflow_q;
    bus.underflow    = underflow_q;
  end
endmodule

// File: tb/tb_ff_fifo_any_depth_with_levels.sv
// Self-checking bench: directed scenarios on a default depth-5 FIFO plus a
// randomized run on depth-5 and depth-8 FIFOs against a queue model.
module tb_ff_fifo_any_depth_with_levels;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ff_fifo_any_depth_with_levels_if #(.width(8), .depth(5)) ifa ();
  ff_fifo_any_depth_with_levels_if #(.width(8), .depth(5)) ifb ();
  ff_fifo_any_depth_with_levels_if #(.width(8), .depth(8)) ifc ();

  ff_fifo_any_depth_with_levels #(.width(8), .depth(5)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  ff_fifo_any_depth_with_levels #(
    .width(8), .depth(5), .almost_full_level(3), .almost_empty_level(2)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  ff_fifo_any_depth_with_levels #(
    .width(8), .depth(8), .almost_full_level(3), .almost_empty_level(2)
  ) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.push = 0; ifa.pop = 0; ifa.write_data = '0;
    ifb.push = 0; ifb.pop = 0; ifb.write_data = '0;
    ifc.push = 0; ifc.pop = 0; ifc.write_data = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic fill_a(input logic [7:0] base);
    for (int i = 0; i < 5; i++) begin
      ifa.push = 1; ifa.write_data = base + 8'(i);
      step();
    end
    ifa.push = 0;
  endtask

  task automatic drain_a(input string name, input logic [7:0] exp [5]);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifa.read_data !== exp[i]) begin
        errors++;
        $display("FAIL %s[%0d] read_data got=%h exp=%h", name, i, ifa.read_data, exp[i]);
      end
      ifa.pop = 1;
      step();
    end
    ifa.pop = 0;
    checks++;
    if (ifa.empty !== 1'b1 || ifa.count !== 3'd0) begin
      errors++;
      $display("FAIL %s_empty got empty=%b count=%0d exp empty=1 count=0", name, ifa.empty, ifa.count);
    end
  endtask

  task automatic test_reset();
    idle_all();
    do_reset();
    checks++;
    if ({ifa.empty, ifa.full, ifa.almost_empty, ifa.almost_full, ifa.overflow, ifa.underflow} !== 6'b101000
        || ifa.count !== 3'd0) begin
      errors++;
      $display("FAIL reset flags got e/f/ae/af/ov/un=%b%b%b%b%b%b count=%0d exp=101000 count=0",
               ifa.empty, ifa.full, ifa.almost_empty, ifa.almost_full, ifa.overflow, ifa.underflow, ifa.count);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = 8'(i * 8'h11);
      ifa.push = 1; ifa.write_data = v;
      step();
      checks++;
      if (ifa.count !== 3'(i + 1) || ifa.almost_full !== (i + 1 >= 4) || ifa.full !== (i + 1 == 5)) begin
        errors++;
        $display("FAIL fill[%0d] got count=%0d af=%b full=%b exp count=%0d af=%b full=%b",
                 i, ifa.count, ifa.almost_full, ifa.full, i + 1, (i + 1 >= 4), (i + 1 == 5));
      end
    end
    ifa.push = 0;
    for (int i = 0; i < 5; i++) begin
      v = 8'(i * 8'h11);
      checks++;
      if (ifa.read_data !== v) begin
        errors++;
        $display("FAIL drain[%0d] read_data got=%h exp=%h", i, ifa.read_data, v);
      end
      ifa.pop = 1;
      step();
      checks++;
      if (ifa.count !== 3'(4 - i) || ifa.almost_empty !== (4 - i <= 1) || ifa.empty !== (i == 4)) begin
        errors++;
        $display("FAIL drain_flags[%0d] got count=%0d ae=%b empty=%b exp count=%0d ae=%b empty=%b",
                 i, ifa.count, ifa.almost_empty, ifa.empty, 4 - i, (4 - i <= 1), (i == 4));
      end
    end
    ifa.pop = 0;
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ifa.push = 1; ifa.write_data = 8'hB0 + 8'(i); step();
    end
    ifa.push = 0;
    for (int i = 0; i < 3; i++) begin
      ifa.pop = 1; step();
    end
    ifa.pop = 0;
    for (int i = 0; i < 4; i++) begin
      ifa.push = 1; ifa.write_data = 8'hA0 + 8'(i); step();
      checks++;
      if (ifa.count > 3'd4) begin
        errors++;
        $display("FAIL wrap_count got=%0d exp<=4", ifa.count);
      end
    end
    ifa.push = 0;
    for (int i = 0; i < 4; i++) begin
      v = 8'hA0 + 8'(i);
      checks++;
      if (ifa.read_data !== v) begin
        errors++;
        $display("FAIL wrap_data[%0d] got=%h exp=%h", i, ifa.read_data, v);
      end
      ifa.pop = 1; step();
    end
    ifa.pop = 0;
    checks++;
    if (ifa.overflow !== 1'b0 || ifa.underflow !== 1'b0 || ifa.empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_flags got ov=%b un=%b empty=%b exp 0 0 1", ifa.overflow, ifa.underflow, ifa.empty);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [5];
    do_reset();
    fill_a(8'h01);
    ifa.push = 1; ifa.pop = 1; ifa.write_data = 8'h66;
    step();
    ifa.push = 0; ifa.pop = 0;
    checks++;
    if (ifa.count !== 3'd5 || ifa.full !== 1'b1 || ifa.read_data !== 8'h02 || ifa.overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop got count=%0d full=%b rd=%h ov=%b exp 5 1 02 0",
               ifa.count, ifa.full, ifa.read_data, ifa.overflow);
    end
    exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h66};
    drain_a("full_pushpop_drain", exp);
  endtask

  task automatic test_overflow();
    logic [7:0] exp [5];
    do_reset();
    fill_a(8'h01);
    ifa.push = 1; ifa.write_data = 8'h77;
    step();
    ifa.push = 0;
    checks++;
    if (ifa.count !== 3'd5 || ifa.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow got count=%0d ov=%b exp 5 1", ifa.count, ifa.overflow);
    end
    step();
    checks++;
    if (ifa.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got=%b exp=1", ifa.overflow);
    end
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    drain_a("overflow_drain", exp);
    do_reset();
    checks++;
    if (ifa.overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got=%b exp=0", ifa.overflow);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    ifa.push = 1; ifa.pop = 1; ifa.write_data = 8'h12;
    step();
    ifa.push = 0; ifa.pop = 0;
    checks++;
    if (ifa.count !== 3'd1 || ifa.underflow !== 1'b1 || ifa.read_data !== 8'h12 || ifa.empty !== 1'b0) begin
      errors++;
      $display("FAIL underflow got count=%0d un=%b rd=%h empty=%b exp 1 1 12 0",
               ifa.count, ifa.underflow, ifa.read_data, ifa.empty);
    end
    ifa.pop = 1; step();
    step();
    ifa.pop = 0;
    checks++;
    if (ifa.count !== 3'd0 || ifa.underflow !== 1'b1 || ifa.overflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_again got count=%0d un=%b ov=%b exp 0 1 0", ifa.count, ifa.underflow, ifa.overflow);
    end
  endtask

  // Queue model for the two randomized instances (index 0: depth 5, 1: depth 8).
  task automatic test_random();
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         dep [2] = '{5, 8};
    bit         mov [2] = '{0, 0};
    bit         mun [2] = '{0, 0};
    bit         p, r, do_rst;
    logic [7:0] d, head;
    int         sz;
    bit         push_ok, pop_ok;
    logic [3:0] oc;
    logic [7:0] ord;
    logic       oe, of, oae, oaf, oov, oun;

    do_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      p = ($urandom_range(0, 99) < ((cyc < 500) ? 60 : 50));
      r = ($urandom_range(0, 99) < ((cyc < 500) ? 50 : 60));
      d = 8'($urandom);
      do_rst = (cyc == 500) || (cyc == 777);
      ifb.push = p; ifb.pop = r; ifb.write_data = d;
      ifc.push = p; ifc.pop = r; ifc.write_data = d;
      rst = do_rst;
      for (int k = 0; k < 2; k++) begin
        sz   = (k == 0) ? q0.size() : q1.size();
        ord  = (k == 0) ? ifb.read_data : ifc.read_data;
        if (!do_rst && r && sz > 0) begin
          head = (k == 0) ? q0[0] : q1[0];
          checks++;
          if (ord !== head) begin
            errors++;
            $display("FAIL rand%0d_data cyc=%0d got=%h exp=%h", k, cyc, ord, head);
          end
        end
      end
      step();
      rst = 0;
      for (int k = 0; k < 2; k++) begin
        sz = (k == 0) ? q0.size() : q1.size();
        if (do_rst) begin
          if (k == 0) q0.delete(); else q1.delete();
          mov[k] = 0; mun[k] = 0;
        end else begin
          pop_ok  = r && sz > 0;
          push_ok = p && (sz < dep[k] || r);
          if (p && !push_ok) mov[k] = 1;
          if (r && sz == 0)  mun[k] = 1;
          if (pop_ok)  begin if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front()); end
          if (push_ok) begin if (k == 0) q0.push_back(d); else q1.push_back(d); end
        end
        sz = (k == 0) ? q0.size() : q1.size();
        if (k == 0) begin
          oc = 4'(ifb.count); oe = ifb.empty; of = ifb.full; oae = ifb.almost_empty;
          oaf = ifb.almost_full; oov = ifb.overflow; oun = ifb.underflow;
        end else begin
          oc = ifc.count; oe = ifc.empty; of = ifc.full; oae = ifc.almost_empty;
          oaf = ifc.almost_full; oov = ifc.overflow; oun = ifc.underflow;
        end
        checks++;
        if (oc !== 4'(sz) || oe !== (sz == 0) || of !== (sz == dep[k]) || oae !== (sz <= 2)
            || oaf !== (sz >= 3) || oov !== mov[k] || oun !== mun[k]) begin
          errors++;
          $display("FAIL rand%0d_state cyc=%0d got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b exp cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b",
                   k, cyc, oc, oe, of, oae, oaf, oov, oun,
                   sz, (sz == 0), (sz == dep[k]), (sz <= 2), (sz >= 3), mov[k], mun[k]);
        end
      end
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_push_pop();
    test_overflow();
    test_underflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ff_fifo_any_depth_with_levels.md
Name: ff_fifo_any_depth_with_levels

Overview:
Flip-flop based show-ahead FIFO; successor to the power-of-two-depth FIFO.
- Accepts any depth >= 2. Pointers wrap explicitly, not by bit overflow.
- Adds an occupancy count, programmable almost_full / almost_empty flags and sticky overflow / underflow error flags.
- Used as a general buffer between pipeline stages where depth is set by latency budget rather than power of two.

Parameters:
width, 8, data bit width (>= 1)
depth, 5, number of entries (>= 2, any integer)
almost_full_level, depth-1, almost_full asserted when count >= this value (1..depth)
almost_empty_level, 1, almost_empty asserted when count <= this value (0..depth-1)
allow_push_when_full_with_pop, 1, 1: simultaneous push+pop while full is legal; 0: push while full is always illegal

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
push  input  1  write request
pop  input  1  read request (acknowledges current read_data)
write_data  input  width  data written on legal push
read_data  output  width  head entry, valid whenever empty=0 (show-ahead)
empty  output  1  count == 0
full  output  1  count == depth
count  output  $clog2(depth+1)  current occupancy 0..depth
almost_empty  output  1  count <= almost_empty_level
almost_full  output  1  count >= almost_full_level
overflow  output  1  sticky: an illegal push was attempted
underflow  output  1  sticky: a pop was attempted while empty

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0 (almost_full_level>=1), overflow=0, underflow=0.
  - Storage array is not reset; read_data is don't-care while empty.
  - Reset mid-operation discards all contents in that cycle. Push/pop in the reset cycle are ignored.
- Pointers: width $clog2(depth), minimum 1. Increment rule: next = (ptr == depth-1) ? 0 : ptr+1. Pointer values >= depth never occur.
- Full/empty derive from the count register, never from pointer comparison. All flags are combinational from count, so they have zero latency after the clock edge.
- Legal pop: pop & ~empty. On the edge, rd_ptr advances. read_data shows the new head in the same cycle the pointer updates.
- Legal push:
  - push & ~full, or
  - push & full & pop & allow_push_when_full_with_pop.
  - On the edge, write_data is stored at wr_ptr and wr_ptr advances.
- Count update:
  - +1 on legal push only.
  - -1 on legal pop only.
  - Unchanged on both or neither.
- Simultaneous push+pop while empty: the push is accepted; the pop is illegal. Count becomes 1 and underflow is set. There is no bypass: read_data reflects the write one cycle later, when empty falls.
- Simultaneous push+pop while full with allow=1: both are accepted, count stays depth, full stays 1, and the head advances.
- Illegal push (full and not covered above): data is dropped, pointers and count are unchanged, and overflow is set to 1.
- Illegal pop (empty): no state change except that underflow is set to 1.
- overflow and underflow clear only on rst.
- read_data latency: data pushed into an empty FIFO at edge N appears on read_data, with empty=0, after edge N.
- Storage is written only on a legal push. Unpushed entries are never read.

Test Plan:
- Reset, then fill and drain (depth=5): push 0x00,0x11,..,0x44 on 5 consecutive cycles.
  - Required during fill: count goes 1..5; almost_full=1 at count 4; full=1 at count 5.
  - Then pop 5 cycles. Required: read_data sequence 00,11,22,33,44; empty=1 after the 5th pop; almost_empty=1 at count<=1.
- Wrap-around: push 3, pop 3, then push 4, pop 4 with values 0xA0..0xA3.
  - Required: order preserved across the ptr 4->0 wrap; count never exceeds 4; no error flags.
- Full with push+pop (allow=1): fill with 1..5, then push 0x66 and pop in the same cycle.
  - Required: count stays 5, full stays 1, read_data=2.
  - A subsequent drain yields 2,3,4,5,0x66.
- Overflow: fill to full, then push 0x77 without pop.
  - Required: count=5, overflow=1 and it remains 1.
  - Drain yields 1..5 (0x77 absent). Assert rst: overflow=0.
- Underflow: on an empty FIFO assert push=1 (0x12) and pop=1 together.
  - Required: count=1, underflow=1, read_data=0x12 the next cycle.
  - A second pop on empty keeps count=0 and underflow=1.
- Randomized reference-model run: 1000 cycles, depth=5 and depth=8, almost_full_level=3, almost_empty_level=2, random push/pop with 50/60% probability.
  - Required: read_data matches a queue model on every legal pop.
  - count and all flags match the model every cycle.
  - Reset inserted mid-run empties the FIFO on the next cycle.
